neunet_mac_wb: RTL and testbench
================================

// Module: neunet_mac_wb
// PURPOSE
// - Writeback/collect end of the 4-lane MAC pipeline: captures result_0..3/nan_0..3 tagged with reg_wen_o/word_sel_o/index_o into a 32-row x 4-lane result regfile.
// - Serves the registered read port that sources datac_0..3 for the next MAC issue.
// - Per-row scoreboard (issue vs. writeback) lets the issuer stall on read-after-write hazards; sticky per-lane NaN flags.
// PARAMETERS
// - NROWS  32  regfile rows; index width = $clog2(NROWS) = 5
// - LANES  4   MAC lanes, fixed; word_sel is a LANES-bit lane write mask
// - CNT_W  4   per-row outstanding counter width; MAC depth 12 < 2**CNT_W
// PORTS
// - clk           in   1    clock
// - reset         in   1    synchronous, active-high
// - wb_wen        in   1    MAC reg_wen_o: result beat valid this cycle
// - wb_word_sel   in   4    MAC word_sel_o: lane write mask
// - wb_index      in   5    MAC index_o: destination row
// - wb_result_0..3 in  32   MAC result_0..3 (IEEE754 single)
// - wb_nan_0..3   in   1    MAC nan_0..3
// - iss_valid     in   1    issuer launched a MAC op with reg_wen=1 this cycle
// - iss_index     in   5    destination row of that op
// - rd_en         in   1    read request
// - rd_index      in   5    row to read
// - rd_valid      out  1    rd_data valid (1 cycle after rd_en)
// - rd_data_0..3  out  32   row contents, lane 0..3
// - pending       out  32   bit r = row r has >=1 outstanding op
// - all_idle      out  1    no row pending
// - nan_sticky    out  4    per-lane sticky NaN seen
// - nan_clr       in   1    clear nan_sticky
// - sb_err        out  1    sticky: counter overflow or writeback to row with count 0
// BEHAVIOUR
// - Reset (sync, active-high): regfile all 0, counters 0, rd_valid=0, rd_data_x=0, pending=0, all_idle=1, nan_sticky=0, sb_err=0. Reset mid-operation drops all in-flight state; beats arriving after reset deassert are written but flag sb_err (count 0).
// - Write: on wb_wen, lane i of row wb_index <= wb_result_i iff wb_word_sel[i]; visible to a read issued the next cycle.
// - Read: rd_en at cycle t -> rd_valid=1 and rd_data_x at t+1; rd_data holds its last value while rd_valid=0.
// - Bypass: rd_en and wb_wen on same index in the same cycle -> lanes with word_sel set return the new wb_result_i, other lanes return stored data.
// - Scoreboard, per row r, next-cycle count:
//   - iss_valid and iss_index==r: +1
//   - wb_wen and wb_index==r: -1; applies even when wb_word_sel==0
//   - both in the same cycle on r: unchanged
//   - increment at 2**CNT_W-1: saturate, set sb_err
//   - decrement at 0: stay 0, set sb_err
// - pending[r] = (count[r]!=0), registered with the counters; all_idle = ~|pending.
// - Issuer contract: iss_valid for index r while pending[r]=1 is legal (WAW); the issuer must hold reads of r until pending[r]=0.
// - NaN: nan_sticky[i] |= wb_wen & wb_word_sel[i] & wb_nan_i.
//   - nan_clr clears nan_sticky; a NaN arriving in the same cycle wins (bit set).
//   - sb_err clears only on reset.
// - All outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
// - Shared package neunet_pkg:
//   - NROWS, LANES, CNT_W, IDX_W
//   - typedef word_t (logic [31:0])
//   - typedef row_t (word_t [LANES-1:0])
//   - typedef idx_t (logic [IDX_W-1:0])
// - Sub-module neunet_sb_cnt, instantiated NROWS times: one row's up/down counter with saturation, error and nonzero outputs.
// - Regfile, bypass mux and NaN logic stay in neunet_mac_wb.
// TESTING
// - Write/read: wb_wen=1, idx=3, sel=4'b1111, results 3F800000/40000000/40400000/40800000; rd_en idx=3 next cycle -> rd_valid at +1, data matches.
// - Partial write + bypass: row 5 = all 11111111; same cycle wb sel=4'b0101 idx=5 results AAAAAAAA and rd_en idx=5 -> rd_data = AAAAAAAA,11111111,AAAAAAAA,11111111.
// - Scoreboard: 3 iss to idx 7 -> pending[7]=1, all_idle=0; 2 wb -> still 1; same-cycle iss+wb on 7 -> still 1; final wb -> pending[7]=0, all_idle=1.
// - Errors:
//   - wb_wen on idx 9 with count 0 -> sb_err=1, count stays 0.
//   - 16 iss to idx 2 without wb -> sb_err=1, count saturates at 15.
// - NaN: wb_nan_2=1 with sel[2]=1 -> nan_sticky=4'b0100; wb_nan_1=1 with sel[1]=0 -> no change; nan_clr plus a new lane-0 NaN in the same cycle -> 4'b0001.
// - Reset mid-flight: 4 iss to idx 1, reset 1 cycle -> all outputs at reset values, rd of row 1 returns 0; a later wb to idx 1 sets sb_err.

Source files
------------

// File: rtl/neunet_pkg.sv
// rtl/neunet_pkg.sv - shared sizes and types for the MAC writeback block
package neunet_pkg;
    localparam int NROWS = 32;
    localparam int LANES = 4;
    localparam int CNT_W = 4;
    localparam int IDX_W = $clog2(NROWS);

    typedef logic [31:0]          word_t;
    typedef word_t [LANES-1:0]    row_t;
    typedef logic [IDX_W-1:0]     idx_t;
endpackage

// File: rtl/neunet_sb_cnt.sv
// rtl/neunet_sb_cnt.sv - one row's outstanding-op counter with saturation and error flag
module neunet_sb_cnt
    import neunet_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic nonzero_o,
    output logic err_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Simultaneous issue and writeback cancel out, so neither edge case applies.
    always_comb begin
        count_d = count_q;
        err_o   = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == CNT_MAX) err_o = 1'b1;
            else                    count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) err_o = 1'b1;
            else               count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) count_q <= '0;
        else         count_q <= count_d;
    end

    assign nonzero_o = |count_q;
endmodule

// File: rtl/neunet_mac_wb.sv
// rtl/neunet_mac_wb.sv - MAC writeback regfile with bypassed read port, RAW scoreboard and NaN flags
module neunet_mac_wb
    import neunet_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_wen,
    input  logic [LANES-1:0] wb_word_sel,
    input  idx_t             wb_index,
    input  word_t            wb_result_0,
    input  word_t            wb_result_1,
    input  word_t            wb_result_2,
    input  word_t            wb_result_3,
    input  logic             wb_nan_0,
    input  logic             wb_nan_1,
    input  logic             wb_nan_2,
    input  logic             wb_nan_3,
    input  logic             iss_valid,
    input  idx_t             iss_index,
    input  logic             rd_en,
    input  idx_t             rd_index,
    output logic             rd_valid,
    output word_t            rd_data_0,
    output word_t            rd_data_1,
    output word_t            rd_data_2,
    output word_t            rd_data_3,
    output logic [NROWS-1:0] pending,
    output logic             all_idle,
    output logic [LANES-1:0] nan_sticky,
    input  logic             nan_clr,
    output logic             sb_err
);
    row_t             wb_row;
    logic [LANES-1:0] wb_nan;
    row_t             mem_q [NROWS];
    row_t             rd_row_d;
    row_t             rd_row_q;
    logic             rd_valid_q;
    logic [LANES-1:0] nan_d;
    logic [LANES-1:0] nan_q;
    logic [NROWS-1:0] cnt_err;
    logic             sb_err_q;

    assign wb_row = {wb_result_3, wb_result_2, wb_result_1, wb_result_0};
    assign wb_nan = {wb_nan_3, wb_nan_2, wb_nan_1, wb_nan_0};

    // Same-cycle writeback to the row being read forwards only the masked lanes.
    always_comb begin
        rd_row_d = mem_q[rd_index];
        if (wb_wen && (wb_index == rd_index)) begin
            for (int i = 0; i < LANES; i++) begin
                if (wb_word_sel[i]) rd_row_d[i] = wb_row[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NROWS; r++) mem_q[r] <= '0;
        end else if (wb_wen) begin
            for (int i = 0; i < LANES; i++) begin
                if (wb_word_sel[i]) mem_q[wb_index][i] <= wb_row[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_row_q   <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_row_q <= rd_row_d;
        end
    end

    // A NaN landing in the clear cycle survives the clear.
    assign nan_d = (nan_clr ? '0 : nan_q) | (wb_wen ? (wb_word_sel & wb_nan) : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            nan_q    <= '0;
            sb_err_q <= 1'b0;
        end else begin
            nan_q    <= nan_d;
            sb_err_q <= sb_err_q | (|cnt_err);
        end
    end

    for (genvar r = 0; r < NROWS; r++) begin : g_row_cnt
        neunet_sb_cnt u_cnt (
            .clk_i     (clk),
            .reset_i   (reset),
            .inc_i     (iss_valid && (iss_index == idx_t'(r))),
            .dec_i     (wb_wen && (wb_index == idx_t'(r))),
            .nonzero_o (pending[r]),
            .err_o     (cnt_err[r])
        );
    end

    assign all_idle   = ~|pending;
    assign rd_valid   = rd_valid_q;
    assign rd_data_0  = rd_row_q[0];
    assign rd_data_1  = rd_row_q[1];
    assign rd_data_2  = rd_row_q[2];
    assign rd_data_3  = rd_row_q[3];
    assign nan_sticky = nan_q;
    assign sb_err     = sb_err_q;
endmodule

// File: tb/tb_neunet_mac_wb.sv
// tb/tb_neunet_mac_wb.sv - scoreboard bench for neunet_mac_wb
module tb_neunet_mac_wb;
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_wen;
    logic [3:0]  wb_word_sel;
    logic [4:0]  wb_index;
    logic [31:0] wb_result_0, wb_result_1, wb_result_2, wb_result_3;
    logic        wb_nan_0, wb_nan_1, wb_nan_2, wb_nan_3;
    logic        iss_valid;
    logic [4:0]  iss_index;
    logic        rd_en;
    logic [4:0]  rd_index;
    logic        rd_valid;
    logic [31:0] rd_data_0, rd_data_1, rd_data_2, rd_data_3;
    logic [31:0] pending;
    logic        all_idle;
    logic [3:0]  nan_sticky;
    logic        nan_clr;
    logic        sb_err;

    int checks   = 0;
    int failures = 0;
    logic [127:0] exp_q [$];

    neunet_mac_wb dut (
        .clk(clk), .reset(reset),
        .wb_wen(wb_wen), .wb_word_sel(wb_word_sel), .wb_index(wb_index),
        .wb_result_0(wb_result_0), .wb_result_1(wb_result_1),
        .wb_result_2(wb_result_2), .wb_result_3(wb_result_3),
        .wb_nan_0(wb_nan_0), .wb_nan_1(wb_nan_1), .wb_nan_2(wb_nan_2), .wb_nan_3(wb_nan_3),
        .iss_valid(iss_valid), .iss_index(iss_index),
        .rd_en(rd_en), .rd_index(rd_index),
        .rd_valid(rd_valid),
        .rd_data_0(rd_data_0), .rd_data_1(rd_data_1),
        .rd_data_2(rd_data_2), .rd_data_3(rd_data_3),
        .pending(pending), .all_idle(all_idle),
        .nan_sticky(nan_sticky), .nan_clr(nan_clr), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [127:0] e;
        logic [127:0] a;
        if (rd_valid === 1'b1) begin
            a = {rd_data_3, rd_data_2, rd_data_1, rd_data_0};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected actual=%h required=no read", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL rd_data actual=%h required=%h", a, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wb_wen = 0; wb_word_sel = 0; wb_index = 0;
        wb_result_0 = 0; wb_result_1 = 0; wb_result_2 = 0; wb_result_3 = 0;
        wb_nan_0 = 0; wb_nan_1 = 0; wb_nan_2 = 0; wb_nan_3 = 0;
        iss_valid = 0; iss_index = 0; rd_en = 0; rd_index = 0; nan_clr = 0;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wb(input logic [4:0] idx, input logic [3:0] sel, input logic [127:0] row);
        wb_wen = 1; wb_index = idx; wb_word_sel = sel;
        {wb_result_3, wb_result_2, wb_result_1, wb_result_0} = row;
    endtask

    task automatic iss(input logic [4:0] idx);
        iss_valid = 1; iss_index = idx;
    endtask

    task automatic rd(input logic [4:0] idx, input logic [127:0] exp_row);
        rd_en = 1; rd_index = idx;
        exp_q.push_back(exp_row);
    endtask

    task automatic reset_state_checks(input string tag);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, {rd_data_3, rd_data_2, rd_data_1, rd_data_0}, 0);
        chk({tag, "_pending"}, pending, 0);
        chk({tag, "_all_idle"}, all_idle, 1);
        chk({tag, "_nan"}, nan_sticky, 0);
        chk({tag, "_sb_err"}, sb_err, 0);
    endtask

    localparam logic [127:0] ROW3 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    localparam logic [127:0] ROW1 = {32'hDEADBEEF, 32'h0BADF00D, 32'h12345678, 32'hCAFEF00D};

    initial begin
        idle_in();
        reset = 1;
        tick(); tick();
        reset = 0;
        reset_state_checks("reset");

        // full write then read of row 3
        iss(3); tick(); idle_in();
        wb(3, 4'b1111, ROW3); tick(); idle_in();
        rd(3, ROW3); tick(); idle_in();
        tick();
        chk("rd_hold", {rd_data_3, rd_data_2, rd_data_1, rd_data_0}, ROW3);
        chk("rd_valid_drop", rd_valid, 0);

        // partial write with same-cycle bypass on row 5
        iss(5); tick(); iss(5); tick(); idle_in();
        wb(5, 4'b1111, {4{32'h11111111}}); tick(); idle_in();
        wb(5, 4'b0101, {4{32'hAAAAAAAA}});
        rd(5, {32'h11111111, 32'hAAAAAAAA, 32'h11111111, 32'hAAAAAAAA});
        tick(); idle_in();
        rd(5, {32'h11111111, 32'hAAAAAAAA, 32'h11111111, 32'hAAAAAAAA});
        tick(); idle_in(); tick();
        chk("sb_err_clean_writes", sb_err, 0);
        chk("idle_after_writes", all_idle, 1);

        // scoreboard on row 7
        for (int i = 0; i < 3; i++) begin iss(7); tick(); end
        idle_in();
        chk("pend7_after_iss", pending[7], 1);
        chk("idle_after_iss", all_idle, 0);
        for (int i = 0; i < 2; i++) begin wb(7, 4'b0000, 0); tick(); end
        idle_in();
        chk("pend7_after_2wb", pending[7], 1);
        iss(7); wb(7, 4'b0000, 0); tick(); idle_in();
        chk("pend7_iss_wb_same", pending[7], 1);
        wb(7, 4'b0000, 0); tick(); idle_in();
        chk("pend7_final", pending[7], 0);
        chk("idle_final", all_idle, 1);
        chk("sb_err_sb_test", sb_err, 0);

        // sticky NaN on row 10
        iss(10); tick(); idle_in();
        wb(10, 4'b0100, 0); wb_nan_2 = 1; tick(); idle_in();
        chk("nan_lane2", nan_sticky, 4'b0100);
        iss(10); tick(); idle_in();
        wb(10, 4'b0001, 0); wb_nan_1 = 1; tick(); idle_in();
        chk("nan_masked", nan_sticky, 4'b0100);
        iss(10); tick(); idle_in();
        wb(10, 4'b0001, 0); wb_nan_0 = 1; nan_clr = 1; tick(); idle_in();
        chk("nan_clr_race", nan_sticky, 4'b0001);
        chk("sb_err_nan_test", sb_err, 0);

        // saturation on row 2
        for (int i = 0; i < 15; i++) begin iss(2); tick(); end
        idle_in();
        chk("sat_no_err_at_15", sb_err, 0);
        iss(2); tick(); idle_in();
        chk("sat_err", sb_err, 1);
        chk("sat_pend2", pending[2], 1);
        for (int i = 0; i < 14; i++) begin wb(2, 4'b0000, 0); tick(); end
        idle_in();
        chk("sat_pend2_after_14wb", pending[2], 1);
        wb(2, 4'b0000, 0); tick(); idle_in();
        chk("sat_pend2_after_15wb", pending[2], 0);

        reset = 1; tick(); reset = 0;
        chk("sb_err_cleared", sb_err, 0);

        // underflow on row 9
        wb(9, 4'b0000, 0); tick(); idle_in();
        chk("underflow_err", sb_err, 1);
        chk("underflow_pend9", pending[9], 0);
        iss(9); tick(); idle_in();
        chk("underflow_count_stayed_0", pending[9], 1);
        wb(9, 4'b0000, 0); tick(); idle_in();
        chk("underflow_pend9_back", pending[9], 0);

        reset = 1; tick(); reset = 0;

        // reset mid-flight on row 1
        for (int i = 0; i < 4; i++) begin iss(1); tick(); end
        idle_in();
        wb(1, 4'b1111, ROW1); wb_nan_3 = 1; tick(); idle_in();
        rd(1, ROW1); tick(); idle_in();
        chk("mid_pend1", pending[1], 1);
        chk("mid_nan", nan_sticky, 4'b1000);
        reset = 1; tick(); reset = 0;
        reset_state_checks("midreset");
        rd(1, 0); tick(); idle_in(); tick();
        wb(1, 4'b0001, {96'h0, 32'h55555555}); tick(); idle_in();
        chk("post_reset_wb_err", sb_err, 1);
        rd(1, {96'h0, 32'h55555555}); tick(); idle_in(); tick(); tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
